md_iter_unit: RTL and testbench
===============================

// Module: md_iter_unit
// PURPOSE
//  Parametrised HI/LO multiply/divide unit for the E stage of the pipelined MIPS CPU.
//  Multiply uses a fixed-latency counter; divide is a real iterative restoring divider (one quotient bit/cycle).
//  Busy is combinational on the issuing op so the hazard unit stalls in the issue cycle; req (exception/interrupt) suppresses issue.
// PARAMETERS
//  XLEN     32  operand / HI / LO width
//  MUL_LAT  5   multiply pipeline cycles (>=1); HI/LO commit at end of cycle MUL_LAT after issue
// PORTS
//  clk      in   1     clock, all state updates on posedge
//  reset    in   1     synchronous, active-high; clears HI, LO, FSM
//  req      in   1     exception/interrupt request; when 1 the op in this cycle is not issued
//  op       in   4     0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo,9 madd,10 maddu,11 msub,12 msubu
//  a        in   XLEN  rs operand (dividend / mthi,mtlo source)
//  b        in   XLEN  rt operand (divisor)
//  busy     out  1     stall request
//  hilo     out  XLEN  mfhi -> HI, mflo -> LO, else 0 (combinational, architectural HI/LO)
// BEHAVIOUR
//  - Reset: HI=LO=0, state IDLE, busy=0 (apart from the comb term below), iteration counter 0, temps 0.
//  - start = op in {1..4, 9..12 (if enabled)}; busy = (start & ~req & IDLE) | (state != IDLE).
//  - FSM: IDLE -> MUL (mult/multu/macc) | DIV (div/divu); MUL counts MUL_LAT..1, commits at 1 -> IDLE;
//    DIV runs XLEN shift/subtract iterations, then FIX (sign fixup + commit) -> IDLE.
//  - Timing, issue in cycle 0: mult busy cycles 0..MUL_LAT, new HI/LO readable cycle MUL_LAT+1;
//    div busy cycles 0..XLEN+1, new HI/LO readable cycle XLEN+2.
//  - mult/multu: {HI,LO} = 2*XLEN-bit signed/unsigned product, computed at issue, held in temps.
//  - div/divu: operate on magnitudes; LO = quotient, HI = remainder; signed: quotient negated if signs differ,
//    remainder takes dividend sign. Operands latched at issue; later changes of a/b are ignored.
//  - Divide by zero (no trap): quotient all ones, remainder = dividend magnitude,
//    then the normal signed fixup applies. Divu by zero: LO=all ones, HI=a.
//  - Overflow div 0x80000000 / -1: LO=0x80000000, HI=0.
//  - mthi/mtlo: write HI/LO at end of cycle, only in IDLE and req=0; never assert busy.
//  - req=1: suppresses issue of any op in IDLE (no start, no mthi/mtlo write). Does NOT abort an in-flight op.
//  - Op presented while state != IDLE: ignored (pipeline is stalled; bench flags it as protocol error).
//  - HI/LO change only on commit, mthi/mtlo, or reset; mfhi/mflo during busy return old architectural value.
//  - Reset mid-operation: FSM to IDLE, result discarded, HI=LO=0 in the next cycle.
// CONFIGURATION
//  MD_MACC_EN defined: ops 9-12 supported, MUL latency:
//    madd {HI,LO} += signed product; maddu += unsigned product; msub/msubu subtract; wrap mod 2^(2*XLEN).
//    The accumulation uses HI/LO as sampled at issue.
//  MD_MACC_EN undefined: ops 9-12 decode as none; busy stays 0, HI/LO unchanged.
// TESTING
//  1 reset; mult a=0xFFFFFFFE b=3 -> busy=1 cycles 0..5, cycle 6 mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA
//  2 divu 100/7 -> busy 34 cycles, then LO=14 HI=2; div -7/2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF
//  3 divu 5/0 -> LO=0xFFFFFFFF HI=5; div 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0
//  4 req=1 with op=mult, then req=1 with op=mthi a=0x1234 -> busy=0 both cycles, HI/LO unchanged
//  5 div issued, reset at cycle 10 -> cycle 11 busy=0, mfhi=mflo=0; later op=div not issued if req=1
//  6 MD_MACC_EN: mtlo 1, madd a=0xFFFFFFFF b=2 -> HI=0xFFFFFFFF LO=0xFFFFFFFF; undefined -> busy 0, LO stays 1

Source files
------------

// File: rtl/md_iter_unit.sv
// ---------------------------------------------------------------------------
// md_iter_unit
//
// HI/LO multiply/divide unit for the E stage of a pipelined MIPS core.
// Multiplies are computed in one shot at issue and then held for a fixed
// MUL_LAT-cycle countdown. Divides run a real restoring divider producing one
// quotient bit per cycle, followed by one sign-fixup/commit cycle.
//
// Optional feature macro: MD_MACC_EN
//   defined   : ops 9..12 (madd, maddu, msub, msubu) accumulate into HI/LO
//               with multiply latency
//   undefined : ops 9..12 decode as "none"
//
// Parameters
//   XLEN     operand / HI / LO width
//   MUL_LAT  multiply latency (>= 1); HI/LO commit at end of cycle MUL_LAT
//
// Ports
//   clk    in   1     clock, all state updates on posedge
//   reset  in   1     synchronous active-high reset (HI, LO, FSM, temps)
//   req    in   1     exception/interrupt request; suppresses issue this cycle
//   op     in   4     0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                     7 mthi,8 mtlo,9 madd,10 maddu,11 msub,12 msubu
//   a      in   XLEN  rs operand (dividend, mthi/mtlo source)
//   b      in   XLEN  rt operand (divisor)
//   busy   out  1     stall request (combinational on the issuing op)
//   hilo   out  XLEN  architectural HI for mfhi, LO for mflo, else 0
// ---------------------------------------------------------------------------
module md_iter_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hilo
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [XLEN-1:0]  ONE     = XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MD_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       hi_q, hi_d;
  logic [XLEN-1:0]       lo_q, lo_d;
  logic [2*XLEN-1:0]     prod_q, prod_d;   // multiply result waiting to commit
  logic [XLEN-1:0]       quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]       rem_q, rem_d;     // partial remainder
  logic [XLEN-1:0]       dvsr_q, dvsr_d;   // divisor magnitude
  logic                  q_neg_q, q_neg_d; // negate quotient at fixup
  logic                  r_neg_q, r_neg_d; // negate remainder at fixup

  // -------------------------------------------------------------------------
  // Op decode
  // -------------------------------------------------------------------------
  logic is_mul, is_div, mul_signed, div_signed;
  logic is_mthi, is_mtlo;
`ifdef MD_MACC_EN
  logic mul_acc, mul_sub;
`endif

  always_comb begin
    is_mul     = 1'b0;
    is_div     = 1'b0;
    mul_signed = 1'b0;
    div_signed = 1'b0;
`ifdef MD_MACC_EN
    mul_acc    = 1'b0;
    mul_sub    = 1'b0;
`endif
    case (op)
      OP_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
      OP_MULTU: begin is_mul = 1'b1; end
      OP_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
      OP_DIVU:  begin is_div = 1'b1; end
`ifdef MD_MACC_EN
      OP_MADD:  begin is_mul = 1'b1; mul_signed = 1'b1; mul_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; mul_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; mul_signed = 1'b1; mul_acc = 1'b1; mul_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; mul_acc = 1'b1; mul_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);

  logic idle, start, issue, wr_ok;

  assign idle  = (state_q == S_IDLE);
  assign start = is_mul | is_div;
  // Only ops seen in IDLE with no pending exception are accepted; anything
  // presented mid-operation is ignored because the pipeline is stalled.
  assign wr_ok = idle & ~req;
  assign issue = start & wr_ok;
  // Combinational term lets the hazard unit stall in the issue cycle itself.
  assign busy  = issue | ~idle;

  // -------------------------------------------------------------------------
  // Multiply datapath (evaluated at issue, result parked in prod_q)
  // -------------------------------------------------------------------------
  logic [2*XLEN-1:0] a_ext, b_ext, prod, mul_res;

  always_comb begin
    a_ext = mul_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    b_ext = mul_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    // Low 2*XLEN bits of the sign-extended product equal the signed product.
    prod  = a_ext * b_ext;
`ifdef MD_MACC_EN
    // Accumulate onto HI/LO as they stand at issue; wraps mod 2^(2*XLEN).
    if (mul_acc) begin
      mul_res = mul_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    end else begin
      mul_res = prod;
    end
`else
    mul_res = prod;
`endif
  end

  // -------------------------------------------------------------------------
  // Divide datapath
  // -------------------------------------------------------------------------
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_fit;

  assign a_neg = div_signed & a[XLEN-1];
  assign b_neg = div_signed & b[XLEN-1];
  assign a_mag = a_neg ? (~a + ONE) : a;
  assign b_mag = b_neg ? (~b + ONE) : b;

  // One restoring step: bring in the next dividend bit, try to subtract.
  // With a zero divisor every trial fits, which yields an all-ones quotient
  // and leaves the dividend magnitude in the remainder.
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, dvsr_q};
  assign div_fit   = ~div_diff[XLEN];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;

    case (state_q)
      S_IDLE: begin
        if (wr_ok) begin
          if (is_mthi) hi_d = a;
          if (is_mtlo) lo_d = a;
          if (is_mul) begin
            prod_d  = mul_res;
            cnt_d   = CNT_W'(MUL_LAT);
            state_d = S_MUL;
          end
          if (is_div) begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvsr_d  = b_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            cnt_d   = CNT_W'(XLEN);
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        if (cnt_q == CNT_ONE) begin
          hi_d    = prod_q[2*XLEN-1:XLEN];
          lo_d    = prod_q[XLEN-1:0];
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DIV: begin
        quo_d = {quo_q[XLEN-2:0], div_fit};
        rem_d = div_fit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_FIX;
      end

      S_FIX: begin
        // Most-negative / -1 falls out naturally: negating 2^(XLEN-1)
        // reproduces itself, and the remainder is zero.
        lo_d    = q_neg_q ? (~quo_q + ONE) : quo_q;
        hi_d    = r_neg_q ? (~rem_q + ONE) : rem_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  // -------------------------------------------------------------------------
  // Architectural HI/LO read port
  // -------------------------------------------------------------------------
  always_comb begin
    hilo = '0;
    if (op == OP_MFHI)      hilo = hi_q;
    else if (op == OP_MFLO) hilo = lo_q;
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_md_iter_unit
//
// Self-checking bench for md_iter_unit (XLEN=32, MUL_LAT=5). Directed vector
// table, hand-written multi-cycle sequences (req suppression, mid-operation
// reset, reads during busy, accumulate ops) and randomized ops checked
// against an arithmetic reference model. Honours MD_MACC_EN like the design.
// ---------------------------------------------------------------------------
module tb_md_iter_unit;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 5;
  localparam int LAT_MUL = MUL_LAT + 1;
  localparam int LAT_DIV = XLEN + 2;
  localparam int MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hilo;

  md_iter_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hilo  (hilo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference-model architectural state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read HI and LO through the combinational port; called in the low phase.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    op = 4'd5; #1 hi = hilo;
    op = 4'd6; #1 lo = hilo;
    op = 4'd0;
  endtask

  // Present one op for a cycle and count how many cycles busy is seen.
  // Operands are scrambled while busy to show they were latched at issue.
  // Returns in the low phase of a cycle with the unit idle and op=none.
  task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic rq, output int lat);
    @(negedge clk);
    op = o; a = av; b = bv; req = rq;
    #1;
    lat = 0;
    while (busy && lat < MAX_WAIT) begin
      lat++;
      @(negedge clk);
      op = 4'd0; req = 1'b0; a = $urandom; b = $urandom;
      #1;
    end
    if (lat == 0) begin
      @(negedge clk);
      op = 4'd0; req = 1'b0;
      #1;
    end
  endtask

  // Reference model: arithmetic straight from the op definitions.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                             input logic rq, output int lat);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = {32'd0, av};
    ub  = {32'd0, bv};
    lat = 0;
    if (rq) return;
    case (o)
      4'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; lat = LAT_MUL; end
      4'd2: begin p = ua * ub;      {m_hi, m_lo} = p; lat = LAT_MUL; end
      4'd3: begin
        lat = LAT_DIV;
        if (bv == 32'd0) begin
          // all-ones magnitude quotient, negated when the dividend is negative
          m_lo = av[31] ? 32'd1 : 32'hFFFF_FFFF;
          m_hi = av;
        end else begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      4'd4: begin
        lat = LAT_DIV;
        if (bv == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = av;
        end else begin
          m_lo = av / bv;
          m_hi = av % bv;
        end
      end
      4'd7: m_hi = av;
      4'd8: m_lo = av;
`ifdef MD_MACC_EN
      4'd9:  begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb); lat = LAT_MUL; end
      4'd10: begin {m_hi, m_lo} = {m_hi, m_lo} + ua * ub;     lat = LAT_MUL; end
      4'd11: begin {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb); lat = LAT_MUL; end
      4'd12: begin {m_hi, m_lo} = {m_hi, m_lo} - ua * ub;     lat = LAT_MUL; end
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'd1;
      4: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          lat;
    int          exp_lat;
    logic [31:0] rh, rl;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        rq;

    // ---------------- vector table (sequential HI/LO expectations) --------
    vecs[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,         LAT_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{4'd4, 32'd100,       32'd7,         LAT_DIV, 32'd2,         32'd14};
    vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,         LAT_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{4'd4, 32'd5,         32'd0,         LAT_DIV, 32'd5,         32'hFFFF_FFFF};
    vecs[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, LAT_DIV, 32'd0,         32'h8000_0000};
    vecs[5]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6]  = '{4'd3, 32'd7,         32'hFFFF_FFFE, LAT_DIV, 32'd1,         32'hFFFF_FFFD};
    vecs[7]  = '{4'd3, 32'hFFFF_FFF8, 32'd0,         LAT_DIV, 32'hFFFF_FFF8, 32'd1};
    vecs[8]  = '{4'd7, 32'h0000_1234, 32'd9,         0,       32'h0000_1234, 32'd1};
    vecs[9]  = '{4'd8, 32'h0000_ABCD, 32'd9,         0,       32'h0000_1234, 32'h0000_ABCD};
    vecs[10] = '{4'd1, 32'd0,         32'd5,         LAT_MUL, 32'd0,         32'd0};

    // ---------------- reset state ----------------
    reset = 1'b1; req = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check32("reset_busy", 32'(busy), 32'd0);
    read_hilo(rh, rl);
    check32("reset_hi", rh, 32'd0);
    check32("reset_lo", rl, 32'd0);
    $display("txn reset: busy=%0d hi=0x%08h lo=0x%08h", busy, rh, rl);

    // ---------------- directed table ----------------
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      read_hilo(rh, rl);
      check32($sformatf("vec%0d_busy_cycles", i), 32'(lat), 32'(vecs[i].lat));
      check32($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
      check32($sformatf("vec%0d_lo", i), rl, vecs[i].lo);
      $display("txn vec%0d op=%0d a=0x%08h b=0x%08h busy_cycles=%0d hi=0x%08h lo=0x%08h",
               i, vecs[i].op, vecs[i].a, vecs[i].b, lat, rh, rl);
    end

    // ---------------- reads during busy return old HI/LO ----------------
    run_op(4'd7, 32'h55, 32'd0, 1'b0, lat);
    run_op(4'd8, 32'h66, 32'd0, 1'b0, lat);
    @(negedge clk);
    op = 4'd1; a = 32'd3; b = 32'd4; req = 1'b0;
    #1 check32("issue_busy", 32'(busy), 32'd1);
    @(negedge clk);
    op = 4'd5; #1;
    check32("busy_mid_mult", 32'(busy), 32'd1);
    check32("mfhi_during_busy", hilo, 32'h55);
    op = 4'd6; #1;
    check32("mflo_during_busy", hilo, 32'h66);
    op = 4'd0;
    lat = 0;
    while (busy && lat < MAX_WAIT) begin
      @(negedge clk); #1; lat++;
    end
    check32("mult_wait_bound", 32'(lat < MAX_WAIT), 32'd1);
    read_hilo(rh, rl);
    check32("mult_after_hi", rh, 32'd0);
    check32("mult_after_lo", rl, 32'd12);
    $display("txn busy-read: hi=0x%08h lo=0x%08h", rh, rl);

    // ---------------- req suppresses issue and mthi ----------------
    @(negedge clk);
    op = 4'd1; a = 32'd7; b = 32'd7; req = 1'b1;
    #1 check32("req_mult_busy", 32'(busy), 32'd0);
    @(negedge clk);
    op = 4'd7; a = 32'h1234; req = 1'b1;
    #1 check32("req_mthi_busy", 32'(busy), 32'd0);
    @(negedge clk);
    op = 4'd0; req = 1'b0;
    #1 check32("req_no_start", 32'(busy), 32'd0);
    read_hilo(rh, rl);
    check32("req_hi_kept", rh, 32'd0);
    check32("req_lo_kept", rl, 32'd12);
    $display("txn req-suppress: hi=0x%08h lo=0x%08h", rh, rl);

    // ---------------- reset in the middle of a divide ----------------
    run_op(4'd7, 32'hAA, 32'd0, 1'b0, lat);
    run_op(4'd8, 32'hBB, 32'd0, 1'b0, lat);
    @(negedge clk);
    op = 4'd3; a = 32'd100; b = 32'd7;   // cycle 0
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      op = 4'd0;
    end
    #1 check32("div_busy_c9", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;                        // cycle 10
    @(negedge clk);
    reset = 1'b0;                        // cycle 11
    #1 check32("rst_mid_busy", 32'(busy), 32'd0);
    read_hilo(rh, rl);
    check32("rst_mid_hi", rh, 32'd0);
    check32("rst_mid_lo", rl, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    op = 4'd3; a = 32'd9; b = 32'd2; req = 1'b1;
    #1 check32("req_div_busy", 32'(busy), 32'd0);
    @(negedge clk);
    op = 4'd0; req = 1'b0;
    #1 check32("req_div_no_start", 32'(busy), 32'd0);
    $display("txn reset-mid-div: hi=0x%08h lo=0x%08h", rh, rl);

    // ---------------- multiply-accumulate ----------------
    run_op(4'd8, 32'd1, 32'd0, 1'b0, lat);
    run_op(4'd9, 32'hFFFF_FFFF, 32'd2, 1'b0, lat);
    read_hilo(rh, rl);
`ifdef MD_MACC_EN
    check32("madd_busy_cycles", 32'(lat), 32'(LAT_MUL));
    check32("madd_hi", rh, 32'hFFFF_FFFF);
    check32("madd_lo", rl, 32'hFFFF_FFFF);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFF;
`else
    check32("madd_off_busy", 32'(lat), 32'd0);
    check32("madd_off_hi", rh, 32'd0);
    check32("madd_off_lo", rl, 32'd1);
    m_hi = 32'd0; m_lo = 32'd1;
`endif
    $display("txn madd: busy_cycles=%0d hi=0x%08h lo=0x%08h", lat, rh, rl);

    // ---------------- randomized ops against the model ----------------
    for (int i = 0; i < 300; i++) begin
      ro = 4'($urandom_range(0, 12));
      ra = pick_operand();
      rb = pick_operand();
      rq = ($urandom_range(0, 7) == 0);
      model_apply(ro, ra, rb, rq, exp_lat);
      run_op(ro, ra, rb, rq, lat);
      read_hilo(rh, rl);
      check32($sformatf("rnd%0d_busy_cycles", i), 32'(lat), 32'(exp_lat));
      check32($sformatf("rnd%0d_hi", i), rh, m_hi);
      check32($sformatf("rnd%0d_lo", i), rl, m_lo);
      $display("txn rnd%0d op=%0d req=%0d a=0x%08h b=0x%08h busy_cycles=%0d hi=0x%08h lo=0x%08h",
               i, ro, rq, ra, rb, lat, rh, rl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
